// File: rtl/hex_display_if.sv
// Display-side bus of hex_display_mux.
//   master : the value producer (ALU / register bank) - drives value, strobes and mode levels
//   slave  : the display multiplexer - drives segment/digit pins and frame_done
// Signals: value_in[7:0], load, dp_in, blank_lead, blink_in,
//          seg_out[6:0] {g..a}, dp_out, digit_en[1:0], frame_done
interface hex_display_if;
  logic [7:0] value_in;
  logic       load;
  logic       dp_in;
  logic       blank_lead;
  logic       blink_in;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [1:0] digit_en;
  logic       frame_done;

  modport master (
    output value_in, load, dp_in, blank_lead, blink_in,
    input  seg_out, dp_out, digit_en, frame_done
  );

  modport slave (
    input  value_in, load, dp_in, blank_lead, blink_in,
    output seg_out, dp_out, digit_en, frame_done
  );
endinterface

// File: rtl/hex_display_mux.sv
// Two-digit multiplexed 7-segment hex display driver.
// Scans SHOW_LO -> GUARD_HI -> SHOW_HI -> GUARD_LO over one shared segment bus,
// with anti-ghosting gaps, decimal point on digit 0, leading-zero blanking of
// digit 1 and whole-display blink. All outputs are registered (1-cycle latency).
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    hex_display_if.slave (value/load/dp/blank/blink in; seg/dp/digit_en/frame_done out)
module hex_display_mux #(
  parameter logic [23:0] REFRESH_DIV  = 24'd10_000,
  parameter logic [7:0]  GUARD_CYCLES = 8'd4,
  parameter logic [7:0]  BLINK_FRAMES = 8'd50
) (
  input  logic         clk,
  input  logic         reset,
  hex_display_if.slave bus
);

  typedef enum logic [1:0] {SHOW_LO, GUARD_HI, SHOW_HI, GUARD_LO} state_t;

  state_t      state, state_nxt;
  logic [23:0] cnt;
  logic        last;
  logic [7:0]  value_q;
  logic        dp_q;
  logic        hi_end_q;   // last SHOW_HI cycle seen; becomes frame_done one edge later
  logic [7:0]  frame_cnt;
  logic        blink_on;   // blink phase: 1 = ON
  logic [6:0]  seg_d;
  logic [1:0]  en_d;
  logic        dp_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  // Next state and registered-output precompute
  always_comb begin
    state_nxt = state;
    en_d      = 2'b00;
    seg_d     = 7'h00;
    dp_d      = 1'b0;

    if (state == SHOW_LO || state == SHOW_HI)
      last = (cnt == REFRESH_DIV - 24'd1);
    else
      last = (cnt == {16'd0, GUARD_CYCLES} - 24'd1);

    if (last) begin
      case (state)
        SHOW_LO:  state_nxt = (GUARD_CYCLES == 8'd0) ? SHOW_HI : GUARD_HI;
        GUARD_HI: state_nxt = SHOW_HI;
        SHOW_HI:  state_nxt = (GUARD_CYCLES == 8'd0) ? SHOW_LO : GUARD_LO;
        default:  state_nxt = SHOW_LO;
      endcase
    end

    case (state)
      SHOW_LO: begin
        en_d  = 2'b01;
        seg_d = decode(value_q[3:0]);
        dp_d  = dp_q;
      end
      SHOW_HI: begin
        en_d  = 2'b10;
        // Blanking only hides segments; the digit slot keeps its timing
        seg_d = (bus.blank_lead && value_q[7:4] == 4'h0) ? 7'h00 : decode(value_q[7:4]);
      end
      default: ;
    endcase

    if (bus.blink_in && !blink_on) begin
      en_d  = 2'b00;
      seg_d = 7'h00;
      dp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SHOW_LO;
      cnt            <= 24'd0;
      value_q        <= 8'h00;
      dp_q           <= 1'b0;
      hi_end_q       <= 1'b0;
      frame_cnt      <= 8'd0;
      blink_on       <= 1'b1;
      bus.seg_out    <= 7'h00;
      bus.dp_out     <= 1'b0;
      bus.digit_en   <= 2'b00;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= last ? 24'd0 : cnt + 24'd1;

      if (bus.load) begin
        value_q <= bus.value_in;
        dp_q    <= bus.dp_in;
      end

      hi_end_q <= (state == SHOW_HI) && last;

      if (hi_end_q) begin
        if (frame_cnt == BLINK_FRAMES - 8'd1) begin
          frame_cnt <= 8'd0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end

      bus.seg_out    <= seg_d;
      bus.dp_out     <= dp_d;
      bus.digit_en   <= en_d;
      bus.frame_done <= hi_end_q;
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
module tb_hex_display_mux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  hex_display_if dif();

  hex_display_mux #(
    .REFRESH_DIV (24'd4),
    .GUARD_CYCLES(8'd2),
    .BLINK_FRAMES(8'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  always #5 clk = ~clk;

  // {frame_done, dp_out, digit_en[1:0], seg_out[6:0]}
  function automatic logic [10:0] obs();
    return {dif.frame_done, dif.dp_out, dif.digit_en, dif.seg_out};
  endfunction

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("%s_rst%0d", tag, i), obs(), 11'h000);
    end
    reset = 1'b0;
  endtask

  // One 12-cycle frame: LO x4, guard x2, HI x4, guard x2 (frame_done on idx 10).
  // Optional load is presented so it is captured on the frame's final edge.
  task automatic check_frame(input string tag, input logic [6:0] lo, input logic [6:0] hi,
                             input logic dp, input logic on,
                             input logic do_ld, input logic [7:0] ld_v, input logic ld_dp);
    logic [10:0] exp;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 11) dif.load = 1'b0;
      if (i < 4)       exp = {1'b0, dp, 2'b01, lo};
      else if (i < 6)  exp = 11'h000;
      else if (i < 10) exp = {1'b0, 1'b0, 2'b10, hi};
      else             exp = 11'h000;
      if (!on) exp = 11'h000;
      if (i == 10) exp[10] = 1'b1;
      chk($sformatf("%s[%0d]", tag, i), obs(), exp);
      if (i == 10 && do_ld) begin
        dif.load     = 1'b1;
        dif.value_in = ld_v;
        dif.dp_in    = ld_dp;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.value_in   = 8'h00;
    dif.load       = 1'b0;
    dif.dp_in      = 1'b0;
    dif.blank_lead = 1'b0;
    dif.blink_in   = 1'b0;

    do_reset("por");
    check_frame("idle",   7'h3F, 7'h3F, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    check_frame("a5",     7'h6D, 7'h77, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0);
    dif.blank_lead = 1'b1;
    check_frame("blank",  7'h07, 7'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    dif.blank_lead = 1'b0;
    check_frame("noblk",  7'h07, 7'h3F, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    check_frame("dp1",    7'h3F, 7'h3F, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    check_frame("dp0",    7'h3F, 7'h3F, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);

    // Partial frame with 8'h3C, then reset lands in the middle of SHOW_HI
    for (int i = 0; i < 7; i++) begin
      step();
      if (i < 4)      chk($sformatf("3c[%0d]", i), obs(), {4'b0001, 7'h39});
      else if (i < 6) chk($sformatf("3c[%0d]", i), obs(), 11'h000);
      else            chk($sformatf("3c[%0d]", i), obs(), {4'b0010, 7'h4F});
    end
    // A load held during reset must not be captured
    dif.load     = 1'b1;
    dif.value_in = 8'hFF;
    dif.dp_in    = 1'b1;
    reset        = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("midrst%0d", i), obs(), 11'h000);
    end
    dif.load = 1'b0;
    dif.dp_in = 1'b0;
    reset = 1'b0;
    check_frame("postrst", 7'h3F, 7'h3F, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Blink: phase starts ON at reset, toggles every 2 frames
    dif.blink_in = 1'b1;
    do_reset("blk");
    check_frame("blk1", 7'h3F, 7'h3F, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_frame("blk2", 7'h3F, 7'h3F, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_frame("blk3", 7'h3F, 7'h3F, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_frame("blk4", 7'h3F, 7'h3F, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_frame("blk5", 7'h3F, 7'h3F, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_frame("blk6", 7'h3F, 7'h3F, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    // Phase is OFF for frame 7, but blink disabled shows the display
    dif.blink_in = 1'b0;
    check_frame("blkoff", 7'h3F, 7'h3F, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
